// File: rtl/hamming_rx_stage.sv
// Hamming SECDED receive stage: extracts data bits from corrected codewords,
// buffers them in a small FIFO and keeps saturating SEC/DED event counts.
module hamming_rx_stage #(
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 8,
  parameter bit DROP_DED = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               code_in,
  input  logic [1:0]               error_flag,
  input  logic [2:0]               error_location,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_data,
  output logic [1:0]               out_err,
  output logic [CNT_W-1:0]         sec_count,
  output logic [CNT_W-1:0]         ded_count,
  output logic [2:0]               last_loc,
  input  logic                     clr_counts,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LAST_LVL = LW'(DEPTH - 1);
  localparam logic [LW-1:0] ONE_LVL  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic [1:0] err;
    logic [3:0] data;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t          state, state_nx;
  entry_t          mem [DEPTH];
  entry_t          wr_entry, head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_nx;
  logic            push, pop;
  logic            is_sec, is_ded, wr_en;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  assign push   = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign is_sec = (error_flag == 2'b01);
  assign is_ded = error_flag[1];
  assign wr_en  = push & ~(is_ded & DROP_DED);

  // Layout [c_all, d3, d2, d1, c2, d0, c1, c0]
  assign wr_entry.err  = error_flag;
  assign wr_entry.data = {code_in[6], code_in[5], code_in[4], code_in[2]};

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head.data : 4'd0;
  assign out_err  = out_valid ? head.err  : 2'd0;

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY:   if (wr_en) state_nx = PARTIAL;
      PARTIAL: begin
        if (wr_en && !pop && level == LAST_LVL)
          state_nx = FULL;
        else if (pop && !wr_en && level == ONE_LVL)
          state_nx = EMPTY;
      end
      FULL:    if (pop) state_nx = PARTIAL;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    level_nx = level;
    unique case (1'b1)
      (wr_en & ~pop): level_nx = level + ONE_LVL;
      (pop & ~wr_en): level_nx = level - ONE_LVL;
      default:        level_nx = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nx;
      level  <= level_nx;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Clear wins over any same-cycle increment or location load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_count <= '0;
      ded_count <= '0;
      last_loc  <= '0;
    end else if (clr_counts) begin
      sec_count <= '0;
      ded_count <= '0;
      last_loc  <= '0;
    end else if (push) begin
      if (is_sec && sec_count != CNT_MAX)
        sec_count <= sec_count + CNT_ONE;
      if (is_sec)
        last_loc <= error_location;
      if (is_ded && ded_count != CNT_MAX)
        ded_count <= ded_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hamming_rx_stage.sv
// Scoreboard bench for hamming_rx_stage: two instances (DED dropped / kept)
// share stimulus and are checked against an occupancy/queue model.
module tb_hamming_rx_stage;

  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int CMAX  = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_counts = 1'b0;
  logic [7:0] code_in = '0;
  logic [1:0] error_flag = '0;
  logic [2:0] error_location = '0;

  logic          in_ready_w  [2];
  logic          out_valid_w [2];
  logic [3:0]    out_data_w  [2];
  logic [1:0]    out_err_w   [2];
  logic [7:0]    sec_w       [2];
  logic [7:0]    ded_w       [2];
  logic [2:0]    loc_w       [2];
  logic [LW-1:0] level_w     [2];

  int vectors = 0;
  int miscompares = 0;

  int m_level [2];
  int m_sec   [2];
  int m_ded   [2];
  int m_loc   [2];
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [5:0] mon_e;

  always #5 clk = ~clk;

  hamming_rx_stage #(.DEPTH(DEPTH), .CNT_W(8), .DROP_DED(1'b1)) u_drop (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .code_in(code_in), .error_flag(error_flag),
    .error_location(error_location),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_data(out_data_w[0]), .out_err(out_err_w[0]),
    .sec_count(sec_w[0]), .ded_count(ded_w[0]),
    .last_loc(loc_w[0]), .clr_counts(clr_counts),
    .level(level_w[0])
  );

  hamming_rx_stage #(.DEPTH(DEPTH), .CNT_W(8), .DROP_DED(1'b0)) u_keep (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .code_in(code_in), .error_flag(error_flag),
    .error_location(error_location),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_data(out_data_w[1]), .out_err(out_err_w[1]),
    .sec_count(sec_w[1]), .ded_count(ded_w[1]),
    .last_loc(loc_w[1]), .clr_counts(clr_counts),
    .level(level_w[1])
  );

  task automatic check(input int inst, input string name,
                       input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s[%0d] @%0t: got %0d expected %0d",
               name, inst, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_level[i] = 0;
      m_sec[i]   = 0;
      m_ded[i]   = 0;
      m_loc[i]   = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Applies the rules for the inputs that were present at the last edge
  task automatic model_step();
    int d;
    bit acc, pop, wr, sec, ded;
    logic [5:0] e;
    d   = int'((code_in >> 2) & 8'd1) + 2 * int'((code_in >> 4) & 8'd7);
    sec = (error_flag == 2'd1);
    ded = (error_flag >= 2'd2);
    for (int i = 0; i < 2; i++) begin
      acc = in_valid && (m_level[i] < DEPTH);
      pop = (m_level[i] > 0) && out_ready;
      wr  = acc && !(ded && i == 0);
      if (wr) begin
        e = {error_flag, 4'(d)};
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      m_level[i] = m_level[i] + int'(wr) - int'(pop);
      if (clr_counts) begin
        m_sec[i] = 0;
        m_ded[i] = 0;
        m_loc[i] = 0;
      end else if (acc) begin
        if (sec) begin
          if (m_sec[i] < CMAX) m_sec[i]++;
          m_loc[i] = int'(error_location);
        end
        if (ded && m_ded[i] < CMAX) m_ded[i]++;
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] c, input logic [1:0] f,
                     input logic [2:0] l, input bit r, input bit clr);
    @(posedge clk);
    #1;
    if (rst_n) model_step();
    #1;
    in_valid       = v;
    code_in        = c;
    error_flag     = f;
    error_location = l;
    out_ready      = r;
    clr_counts     = clr;
  endtask

  task automatic check_reset_vals();
    for (int i = 0; i < 2; i++) begin
      check(i, "rst_out_valid", int'(out_valid_w[i]), 0);
      check(i, "rst_level", int'(level_w[i]), 0);
      check(i, "rst_out_data", int'(out_data_w[i]), 0);
      check(i, "rst_out_err", int'(out_err_w[i]), 0);
      check(i, "rst_sec", int'(sec_w[i]), 0);
      check(i, "rst_ded", int'(ded_w[i]), 0);
      check(i, "rst_loc", int'(loc_w[i]), 0);
    end
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on handshakes
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        check(i, "in_ready", int'(in_ready_w[i]), int'(m_level[i] < DEPTH));
        check(i, "out_valid", int'(out_valid_w[i]), int'(m_level[i] > 0));
        check(i, "level", int'(level_w[i]), m_level[i]);
        check(i, "sec_count", int'(sec_w[i]), m_sec[i]);
        check(i, "ded_count", int'(ded_w[i]), m_ded[i]);
        check(i, "last_loc", int'(loc_w[i]), m_loc[i]);
        if (out_valid_w[i]) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            check(i, "unexpected_out", 1, 0);
          end else begin
            mon_e = (i == 0) ? q0[0] : q1[0];
            check(i, "out_data", int'(out_data_w[i]), int'(mon_e[3:0]));
            check(i, "out_err", int'(out_err_w[i]), int'(mon_e[5:4]));
            if (out_ready) begin
              if (i == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
        end else begin
          check(i, "idle_data", int'(out_data_w[i]), 0);
          check(i, "idle_err", int'(out_err_w[i]), 0);
        end
      end
    end
  end

  initial begin
    model_reset();
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // clean word, then SEC word, then DED word
    cyc(1, 8'b0101_0100, 2'b00, 3'd0, 1, 0);
    cyc(0, 8'h00, 2'b00, 3'd0, 1, 0);
    check(0, "clean_data", int'(out_data_w[0]), 11);
    cyc(1, 8'h7F, 2'b01, 3'd5, 1, 0);
    cyc(0, 8'h00, 2'b00, 3'd0, 1, 0);
    check(0, "sec_data", int'(out_data_w[0]), 15);
    check(0, "sec_loc", int'(loc_w[0]), 5);
    cyc(1, 8'hA5, 2'b10, 3'd2, 1, 0);
    cyc(0, 8'h00, 2'b00, 3'd0, 1, 0);
    check(0, "ded_dropped", int'(out_valid_w[0]), 0);
    check(1, "ded_kept_err", int'(out_err_w[1]), 2);
    check(0, "ded_count", int'(ded_w[0]), 1);

    // fill with no drain, then stream through a full FIFO
    for (int k = 0; k < 5; k++)
      cyc(1, 8'($urandom), 2'b00, 3'd0, 0, 0);
    cyc(0, 8'h00, 2'b00, 3'd0, 0, 0);
    check(0, "full_in_ready", int'(in_ready_w[0]), 0);
    check(0, "full_level", int'(level_w[0]), 4);
    for (int k = 0; k < 8; k++)
      cyc(1, 8'($urandom), 2'b00, 3'd0, 1, 0);
    for (int k = 0; k < 6; k++)
      cyc(0, 8'h00, 2'b00, 3'd0, 1, 0);

    // saturation, then clear racing an accept
    for (int k = 0; k < 260; k++)
      cyc(1, 8'($urandom), 2'b01, 3'($urandom), 1, 0);
    cyc(1, 8'($urandom), 2'b01, 3'd6, 1, 0);
    check(0, "sec_sat", int'(sec_w[0]), 255);
    cyc(1, 8'($urandom), 2'b01, 3'd7, 1, 1);
    cyc(0, 8'h00, 2'b00, 3'd0, 1, 0);
    check(0, "sec_clr", int'(sec_w[0]), 0);
    check(0, "loc_clr", int'(loc_w[0]), 0);

    // randomized traffic
    for (int k = 0; k < 2000; k++)
      cyc($urandom_range(0, 9) < 7, 8'($urandom), 2'($urandom),
          3'($urandom), $urandom_range(0, 9) < 6,
          $urandom_range(0, 99) < 3);

    // reset in the middle of a stream with three words held
    for (int k = 0; k < 6; k++)
      cyc(0, 8'h00, 2'b00, 3'd0, 1, 0);
    cyc(1, 8'h10, 2'b01, 3'd1, 0, 0);
    cyc(1, 8'h20, 2'b01, 3'd2, 0, 0);
    cyc(1, 8'h40, 2'b00, 3'd0, 0, 0);
    cyc(0, 8'h00, 2'b00, 3'd0, 0, 0);
    check(0, "pre_rst_level", int'(level_w[0]), 3);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    cyc(0, 8'h00, 2'b00, 3'd0, 1, 0);
    cyc(0, 8'h00, 2'b00, 3'd0, 1, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 300; k++)
      cyc($urandom_range(0, 1) == 1, 8'($urandom), 2'($urandom),
          3'($urandom), $urandom_range(0, 3) != 0, 0);
    for (int k = 0; k < 8; k++)
      cyc(0, 8'h00, 2'b00, 3'd0, 1, 0);
    @(negedge clk);
    check(0, "drained", q0.size(), 0);
    check(1, "drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
